clz_normalizer: RTL
===================

# clz_normalizer

Multi-cycle count-leading-zeros/ones unit for the MIPS datapath, the inverse of the shifter. It recovers the left-shift amount that normalizes an operand and returns the normalized word. The ALU issues a start pulse, and the unit scans one bit per cycle. It then returns the count (0–32) and the operand shifted left by that count. The result serves CLZ/CLO instructions and normalization for the multiply/divide path.

## Interface
Parameters: none; data width is fixed at 32 bits.

Ports:
- clk  input  1  system clock; all state updates on the rising edge
- reset_n  input  1  asynchronous, active-low reset
- start  input  1  request a scan; sampled only in IDLE
- op  input  1  0 = count leading zeros (CLZ); 1 = count leading ones (CLO), honoured only with CLO_EN
- in  input  32  operand, sampled on the accepting edge only
- busy  output  1  high while in SCAN
- done  output  1  one-cycle pulse when the result is valid
- count  output  6  leading-bit count, range 0..32
- norm_out  output  32  operand shifted left by count, zero-filled (0 when count = 32)

## Operation
- Reset: asynchronous assertion forces IDLE. busy=0, done=0, count=0, norm_out=0, and internal work and op registers are cleared. Reset during SCAN or DONE aborts the scan; no done is produced.
- States: IDLE, SCAN, DONE.
- IDLE:
  - Transition: start=1 moves to SCAN.
  - Work register loads `in`. count loads 0. The effective op is latched.
- SCAN, evaluated each edge:
  - Stop bit is 1 for CLZ and 0 for CLO.
  - If work[31] equals the stop bit, move to DONE with no shift.
  - Otherwise shift work left by 1 with 0 fill and increment count.
  - If count becomes 32 on that edge, move to DONE.
- DONE: done=1 for exactly one cycle, then IDLE.
- Outputs:
  - norm_out mirrors the work register.
  - count and norm_out hold their final values after DONE until the next accepted start reloads them.
- start is ignored in SCAN and DONE. There is no queueing.
- Width rules:
  - count is 6 bits so that 32 is representable.
  - Shifting uses zero fill only; there is no sign extension.
  - count never exceeds 32.

## Timing
- Edge 0 is the edge that samples start=1 in IDLE. From edge 0, busy=1.
- For N leading target bits, DONE is entered at edge min(N+1, 32). done is high for the cycle following that edge.
- Boundary cases:
  - N=0 (MSB already the stop bit): done high after edge 1, count=0, norm_out=in.
  - N=31 and N=32: both take 32 edges.
  - N=32 gives count=32 and norm_out=0.
- busy falls on the same edge that done rises. busy and done are never high together.
- The earliest back-to-back start is sampled in the cycle after done, once back in IDLE.
- While busy or done, changes on `in` or `op` have no effect.

## Configuration
- Macro: CLO_EN.
- With CLO_EN defined:
  - op is latched at accept.
  - op=1 makes the stop bit 0, so the unit counts leading ones.
- Without CLO_EN:
  - op is ignored and the latched op is forced to 0, so the unit always performs CLZ.
  - Port list unchanged.

## Test plan
- CLZ: in=0x00010000, op=0, start pulse -> done 16 cycles after edge 0, count=15, norm_out=0x80000000; busy high for edges 0..15.
- Zero operand: in=0x00000000, op=0 -> done after edge 32, count=32, norm_out=0x00000000.
- MSB set: in=0x80000000, op=0 -> done after edge 1, count=0, norm_out=0x80000000. Then a back-to-back start in the next IDLE cycle with in=0x00000001 -> count=31, norm_out=0x80000000.
- CLO with CLO_EN: in=0xFFF01234, op=1 -> count=12, norm_out=0x01234000. Same stimulus built without CLO_EN -> count=0, norm_out=0xFFF01234.
- Start ignored: in=0x00000100, start, then in=0x80000000 with start=1 held through SCAN -> single done, count=23, norm_out=0x80000000, no second done.
- Async reset mid-scan: in=0x00000001, deassert reset_n asynchronously at edge 10 -> busy, done, count and norm_out read 0 immediately, no done pulse. After release, a new start with in=0x40000000 -> count=1, norm_out=0x80000000.

Source files
------------

// File: rtl/clz_normalizer.sv
// Multi-cycle count-leading-zeros/ones unit: scans one bit per cycle and returns the count
// plus the operand left-normalized by it. Define CLO_EN to honour op=1 (count leading ones).
module clz_normalizer (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] in,
    output logic        busy,
    output logic        done,
    output logic [5:0]  count,
    output logic [31:0] norm_out
);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StScan = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [5:0]  count_q, count_d;
    logic        op_q, op_d;
    logic        op_eff;
    logic        stop_bit;

`ifdef CLO_EN
    assign op_eff = op;
`else
    // Without CLO_EN the port stays but the unit is CLZ only.
    assign op_eff = op & 1'b0;
`endif

    // CLZ stops on the first 1, CLO on the first 0.
    assign stop_bit = ~op_q;

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        count_d = count_q;
        op_d    = op_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StScan;
                    work_d  = in;
                    count_d = 6'd0;
                    op_d    = op_eff;
                end
            end
            StScan: begin
                if (work_q[31] == stop_bit) begin
                    state_d = StDone;
                end else begin
                    work_d  = {work_q[30:0], 1'b0};
                    count_d = count_q + 6'd1;
                    if (count_q == 6'd31) begin
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            work_q  <= 32'd0;
            count_q <= 6'd0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            count_q <= count_d;
            op_q    <= op_d;
        end
    end

    assign busy     = (state_q == StScan);
    assign done     = (state_q == StDone);
    assign count    = count_q;
    assign norm_out = work_q;

endmodule
